// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares the L2 request port between L1D and L1I and tracks L1 flushes.
// Optional: define L1_ARB_ROUND_ROBIN_EN for last-grant tie breaking (else ties go to L1D).
module l1_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int CL_BITS = 128,
    parameter int OPC_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               l1d_mem_req_valid,
    input  logic [ADDR_W-1:0]  l1d_mem_req_addr,
    input  logic [OPC_W-1:0]   l1d_mem_req_opcode,
    input  logic [CL_BITS-1:0] l1d_mem_req_store_data,
    output logic               l1d_mem_rsp_valid,
    input  logic               l1i_mem_req_valid,
    input  logic [ADDR_W-1:0]  l1i_mem_req_addr,
    input  logic [OPC_W-1:0]   l1i_mem_req_opcode,
    output logic               l1i_mem_rsp_valid,
    output logic               l2_req_valid,
    input  logic               l2_req_ack,
    output logic [ADDR_W-1:0]  l2_req_addr,
    output logic [OPC_W-1:0]   l2_req_opcode,
    output logic [CL_BITS-1:0] l2_req_store_data,
    input  logic               l2_rsp_valid,
    input  logic               flush_req_l1d,
    input  logic               flush_req_l1i,
    input  logic               l1d_flush_complete,
    input  logic               l1i_flush_complete,
    output logic               in_flush_mode
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_L1D = 2'd1,
        GNT_L1I = 2'd2,
        RSVD    = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        FIDLE     = 2'd0,
        WAIT_BOTH = 2'd1,
        WAIT_I    = 2'd2,
        WAIT_D    = 2'd3
    } flush_state_t;

    arb_state_t   state, state_nx;
    flush_state_t fstate, fstate_nx;

    logic pend_d, pend_i, last_gnt, req;
    logic pend_d_nx, pend_i_nx, last_gnt_nx, req_nx;
    logic flush_nx;
    logic rsp_d, rsp_i;
    logic n_pend_d, n_pend_i;

    assign n_pend_d = pend_d | l1d_mem_req_valid;
    assign n_pend_i = pend_i | l1i_mem_req_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            fstate        <= FIDLE;
            pend_d        <= 1'b0;
            pend_i        <= 1'b0;
            last_gnt      <= 1'b0;
            req           <= 1'b0;
            in_flush_mode <= 1'b0;
        end else begin
            state         <= state_nx;
            fstate        <= fstate_nx;
            pend_d        <= pend_d_nx;
            pend_i        <= pend_i_nx;
            last_gnt      <= last_gnt_nx;
            req           <= req_nx;
            in_flush_mode <= flush_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        pend_d_nx   = n_pend_d;
        pend_i_nx   = n_pend_i;
        last_gnt_nx = last_gnt;
        req_nx      = req;
        rsp_d       = 1'b0;
        rsp_i       = 1'b0;
        case (state)
            IDLE: begin
                if (n_pend_d && n_pend_i) begin
                    req_nx = 1'b1;
`ifdef L1_ARB_ROUND_ROBIN_EN
                    state_nx = last_gnt ? GNT_L1D : GNT_L1I;
`else
                    state_nx = GNT_L1D;
`endif
                end else if (n_pend_d) begin
                    req_nx   = 1'b1;
                    state_nx = GNT_L1D;
                end else if (n_pend_i) begin
                    req_nx   = 1'b1;
                    state_nx = GNT_L1I;
                end
            end
            GNT_L1D: begin
                last_gnt_nx = 1'b0;
                pend_d_nx   = 1'b0;
                if (l2_req_ack) req_nx = 1'b0;
                if (l2_rsp_valid) begin
                    req_nx   = 1'b0;
                    state_nx = IDLE;
                    rsp_d    = 1'b1;
                end
            end
            GNT_L1I: begin
                last_gnt_nx = 1'b1;
                pend_i_nx   = 1'b0;
                if (l2_req_ack) req_nx = 1'b0;
                if (l2_rsp_valid) begin
                    req_nx   = 1'b0;
                    state_nx = IDLE;
                    rsp_i    = 1'b1;
                end
            end
            default: begin
                pend_d_nx = pend_d;
                pend_i_nx = pend_i;
            end
        endcase
    end

    // Responses are suppressed while reset is held so an aborted grant never completes.
    assign l1d_mem_rsp_valid = rsp_d & reset;
    assign l1i_mem_rsp_valid = rsp_i & reset;
    assign l2_req_valid      = req;
    assign l2_req_addr       = (state == GNT_L1I) ? l1i_mem_req_addr : l1d_mem_req_addr;
    assign l2_req_opcode     = (state == GNT_L1I) ? l1i_mem_req_opcode : l1d_mem_req_opcode;
    assign l2_req_store_data = l1d_mem_req_store_data;

    always_comb begin
        fstate_nx = fstate;
        flush_nx  = in_flush_mode;
        case (fstate)
            FIDLE: begin
                if (flush_req_l1d && flush_req_l1i) begin
                    fstate_nx = WAIT_BOTH;
                    flush_nx  = 1'b1;
                end else if (flush_req_l1i) begin
                    fstate_nx = WAIT_I;
                    flush_nx  = 1'b1;
                end else if (flush_req_l1d) begin
                    fstate_nx = WAIT_D;
                    flush_nx  = 1'b1;
                end
            end
            WAIT_BOTH: begin
                if (l1d_flush_complete && l1i_flush_complete) begin
                    fstate_nx = FIDLE;
                    flush_nx  = 1'b0;
                end else if (l1d_flush_complete) begin
                    fstate_nx = WAIT_I;
                end else if (l1i_flush_complete) begin
                    fstate_nx = WAIT_D;
                end
            end
            WAIT_I: begin
                if (l1i_flush_complete) begin
                    fstate_nx = FIDLE;
                    flush_nx  = 1'b0;
                end
            end
            default: begin
                if (l1d_flush_complete) begin
                    fstate_nx = FIDLE;
                    flush_nx  = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of port ownership and outstanding flushes.
module tb_l1_mem_arbiter;

    localparam int AW = 32;
    localparam int CW = 128;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          l1d_mem_req_valid;
    logic [AW-1:0] l1d_mem_req_addr;
    logic [OW-1:0] l1d_mem_req_opcode;
    logic [CW-1:0] l1d_mem_req_store_data;
    logic          l1d_mem_rsp_valid;
    logic          l1i_mem_req_valid;
    logic [AW-1:0] l1i_mem_req_addr;
    logic [OW-1:0] l1i_mem_req_opcode;
    logic          l1i_mem_rsp_valid;
    logic          l2_req_valid;
    logic          l2_req_ack;
    logic [AW-1:0] l2_req_addr;
    logic [OW-1:0] l2_req_opcode;
    logic [CW-1:0] l2_req_store_data;
    logic          l2_rsp_valid;
    logic          flush_req_l1d;
    logic          flush_req_l1i;
    logic          l1d_flush_complete;
    logic          l1i_flush_complete;
    logic          in_flush_mode;

    int errors = 0;
    int checks = 0;

    l1_mem_arbiter #(.ADDR_W(AW), .CL_BITS(CW), .OPC_W(OW)) dut (
        .clk(clk),
        .reset(reset),
        .l1d_mem_req_valid(l1d_mem_req_valid),
        .l1d_mem_req_addr(l1d_mem_req_addr),
        .l1d_mem_req_opcode(l1d_mem_req_opcode),
        .l1d_mem_req_store_data(l1d_mem_req_store_data),
        .l1d_mem_rsp_valid(l1d_mem_rsp_valid),
        .l1i_mem_req_valid(l1i_mem_req_valid),
        .l1i_mem_req_addr(l1i_mem_req_addr),
        .l1i_mem_req_opcode(l1i_mem_req_opcode),
        .l1i_mem_rsp_valid(l1i_mem_rsp_valid),
        .l2_req_valid(l2_req_valid),
        .l2_req_ack(l2_req_ack),
        .l2_req_addr(l2_req_addr),
        .l2_req_opcode(l2_req_opcode),
        .l2_req_store_data(l2_req_store_data),
        .l2_rsp_valid(l2_rsp_valid),
        .flush_req_l1d(flush_req_l1d),
        .flush_req_l1i(flush_req_l1i),
        .l1d_flush_complete(l1d_flush_complete),
        .l1i_flush_complete(l1i_flush_complete),
        .in_flush_mode(in_flush_mode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        l1d_mem_req_valid      = 1'b0;
        l1d_mem_req_addr       = '0;
        l1d_mem_req_opcode     = '0;
        l1d_mem_req_store_data = '0;
        l1i_mem_req_valid      = 1'b0;
        l1i_mem_req_addr       = '0;
        l1i_mem_req_opcode     = '0;
        l2_req_ack             = 1'b0;
        l2_rsp_valid           = 1'b0;
        flush_req_l1d          = 1'b0;
        flush_req_l1i          = 1'b0;
        l1d_flush_complete     = 1'b0;
        l1i_flush_complete     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        l1d_mem_req_valid = 1'b1;
        l1i_mem_req_valid = 1'b1;
        flush_req_l1d     = 1'b1;
        l2_rsp_valid      = 1'b1;
        l1d_mem_req_addr  = 32'hABCD_0000;
        repeat (2) tick();
        #1;
        checks++;
        if (l2_req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_l2_valid got=%0b exp=0", l2_req_valid);
        end
        checks++;
        if ({l1d_mem_rsp_valid, l1i_mem_rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_rsp got=%0b%0b exp=00", l1d_mem_rsp_valid, l1i_mem_rsp_valid);
        end
        checks++;
        if (in_flush_mode !== 1'b0) begin
            errors++; $display("FAIL reset_flush got=%0b exp=0", in_flush_mode);
        end
        checks++;
        if (l2_req_addr !== 32'hABCD_0000) begin
            errors++; $display("FAIL reset_addr_mux got=%h exp=abcd0000", l2_req_addr);
        end
        clear_inputs();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_d();
        do_reset();
        l1d_mem_req_addr   = 32'h0000_1000;
        l1d_mem_req_opcode = 4'd2;
        l1d_mem_req_valid  = 1'b1;
        #1;
        checks++;
        if (l2_req_valid !== 1'b0) begin
            errors++; $display("FAIL single_early got=%0b exp=0", l2_req_valid);
        end
        tick();
        l1d_mem_req_valid = 1'b0;
        #1;
        checks++;
        if ({l2_req_valid, l2_req_addr, l2_req_opcode} !== {1'b1, 32'h1000, 4'd2}) begin
            errors++;
            $display("FAIL single_grant got=%0b/%h/%0d exp=1/00001000/2", l2_req_valid, l2_req_addr, l2_req_opcode);
        end
        repeat (4) tick();
        #1;
        checks++;
        if (l2_req_valid !== 1'b1) begin
            errors++; $display("FAIL single_hold got=%0b exp=1", l2_req_valid);
        end
        l2_rsp_valid = 1'b1;
        #1;
        checks++;
        if ({l1d_mem_rsp_valid, l1i_mem_rsp_valid} !== 2'b10) begin
            errors++; $display("FAIL single_rsp got=%0b%0b exp=10", l1d_mem_rsp_valid, l1i_mem_rsp_valid);
        end
        tick();
        l2_rsp_valid = 1'b0;
        #1;
        checks++;
        if ({l1d_mem_rsp_valid, l2_req_valid} !== 2'b00) begin
            errors++; $display("FAIL single_after got=%0b%0b exp=00", l1d_mem_rsp_valid, l2_req_valid);
        end
    endtask

    task automatic test_tie();
        logic [AW-1:0] first_addr, second_addr;
        logic          first_is_i;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            l1d_mem_req_addr   = 32'hD000_0000 + AW'(r);
            l1i_mem_req_addr   = 32'h1000_0000 + AW'(r);
            l1d_mem_req_opcode = 4'd3;
            l1i_mem_req_opcode = 4'd5;
`ifdef L1_ARB_ROUND_ROBIN_EN
            first_is_i = 1'b1;
`else
            first_is_i = 1'b0;
`endif
            first_addr  = first_is_i ? l1i_mem_req_addr : l1d_mem_req_addr;
            second_addr = first_is_i ? l1d_mem_req_addr : l1i_mem_req_addr;
            l1d_mem_req_valid = 1'b1;
            l1i_mem_req_valid = 1'b1;
            tick();
            l1d_mem_req_valid = 1'b0;
            l1i_mem_req_valid = 1'b0;
            #1;
            checks++;
            if ({l2_req_valid, l2_req_addr} !== {1'b1, first_addr}) begin
                errors++; $display("FAIL tie_first r=%0d got=%0b/%h exp=1/%h", r, l2_req_valid, l2_req_addr, first_addr);
            end
            l2_rsp_valid = 1'b1;
            #1;
            checks++;
            if ({l1i_mem_rsp_valid, l1d_mem_rsp_valid} !== {first_is_i, ~first_is_i}) begin
                errors++; $display("FAIL tie_first_rsp r=%0d got i=%0b d=%0b", r, l1i_mem_rsp_valid, l1d_mem_rsp_valid);
            end
            tick();
            l2_rsp_valid = 1'b0;
            #1;
            checks++;
            if (l2_req_valid !== 1'b0) begin
                errors++; $display("FAIL tie_gap r=%0d got=%0b exp=0", r, l2_req_valid);
            end
            tick();
            #1;
            checks++;
            if ({l2_req_valid, l2_req_addr} !== {1'b1, second_addr}) begin
                errors++; $display("FAIL tie_second r=%0d got=%0b/%h exp=1/%h", r, l2_req_valid, l2_req_addr, second_addr);
            end
            l2_rsp_valid = 1'b1;
            #1;
            checks++;
            if ({l1i_mem_rsp_valid, l1d_mem_rsp_valid} !== {~first_is_i, first_is_i}) begin
                errors++; $display("FAIL tie_second_rsp r=%0d got i=%0b d=%0b", r, l1i_mem_rsp_valid, l1d_mem_rsp_valid);
            end
            tick();
            l2_rsp_valid = 1'b0;
        end
    endtask

    task automatic test_ack_and_pend();
        do_reset();
        l1d_mem_req_addr  = 32'h0000_2000;
        l1i_mem_req_addr  = 32'h0000_3000;
        l1d_mem_req_valid = 1'b1;
        tick();
        l1d_mem_req_valid = 1'b0;
        tick();
        l2_req_ack        = 1'b1;
        l1i_mem_req_valid = 1'b1;
        #1;
        checks++;
        if (l2_req_valid !== 1'b1) begin
            errors++; $display("FAIL ack_before got=%0b exp=1", l2_req_valid);
        end
        tick();
        l2_req_ack        = 1'b0;
        l1i_mem_req_valid = 1'b0;
        repeat (2) begin
            #1;
            checks++;
            if ({l2_req_valid, l2_req_addr} !== {1'b0, 32'h2000}) begin
                errors++; $display("FAIL ack_dropped got=%0b/%h exp=0/00002000", l2_req_valid, l2_req_addr);
            end
            tick();
        end
        l2_rsp_valid = 1'b1;
        #1;
        checks++;
        if ({l1d_mem_rsp_valid, l1i_mem_rsp_valid} !== 2'b10) begin
            errors++; $display("FAIL ack_rsp got=%0b%0b exp=10", l1d_mem_rsp_valid, l1i_mem_rsp_valid);
        end
        tick();
        l2_rsp_valid = 1'b0;
        #1;
        checks++;
        if (l2_req_valid !== 1'b0) begin
            errors++; $display("FAIL pend_idle got=%0b exp=0", l2_req_valid);
        end
        tick();
        #1;
        checks++;
        if ({l2_req_valid, l2_req_addr} !== {1'b1, 32'h3000}) begin
            errors++; $display("FAIL pend_grant got=%0b/%h exp=1/00003000", l2_req_valid, l2_req_addr);
        end
        l2_rsp_valid = 1'b1;
        #1;
        checks++;
        if ({l1d_mem_rsp_valid, l1i_mem_rsp_valid} !== 2'b01) begin
            errors++; $display("FAIL pend_rsp got=%0b%0b exp=01", l1d_mem_rsp_valid, l1i_mem_rsp_valid);
        end
        tick();
        l2_rsp_valid = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        flush_req_l1d = 1'b1;
        flush_req_l1i = 1'b1;
        #1;
        checks++;
        if (in_flush_mode !== 1'b0) begin
            errors++; $display("FAIL flush_early got=%0b exp=0", in_flush_mode);
        end
        tick();
        flush_req_l1d = 1'b0;
        flush_req_l1i = 1'b0;
        #1;
        checks++;
        if (in_flush_mode !== 1'b1) begin
            errors++; $display("FAIL flush_rise got=%0b exp=1", in_flush_mode);
        end
        repeat (2) tick();
        l1d_flush_complete = 1'b1;
        tick();
        l1d_flush_complete = 1'b0;
        flush_req_l1d      = 1'b1;
        tick();
        flush_req_l1d = 1'b0;
        repeat (2) tick();
        #1;
        checks++;
        if (in_flush_mode !== 1'b1) begin
            errors++; $display("FAIL flush_wait_i got=%0b exp=1", in_flush_mode);
        end
        l1i_flush_complete = 1'b1;
        tick();
        l1i_flush_complete = 1'b0;
        #1;
        checks++;
        if (in_flush_mode !== 1'b0) begin
            errors++; $display("FAIL flush_fall got=%0b exp=0", in_flush_mode);
        end
        flush_req_l1d = 1'b1;
        flush_req_l1i = 1'b1;
        tick();
        flush_req_l1d = 1'b0;
        flush_req_l1i = 1'b0;
        l1d_flush_complete = 1'b1;
        l1i_flush_complete = 1'b1;
        tick();
        l1d_flush_complete = 1'b0;
        l1i_flush_complete = 1'b0;
        #1;
        checks++;
        if (in_flush_mode !== 1'b0) begin
            errors++; $display("FAIL flush_simul got=%0b exp=0", in_flush_mode);
        end
        flush_req_l1i = 1'b1;
        tick();
        flush_req_l1i      = 1'b0;
        l1d_flush_complete = 1'b1;
        tick();
        l1d_flush_complete = 1'b0;
        #1;
        checks++;
        if (in_flush_mode !== 1'b1) begin
            errors++; $display("FAIL flush_wrong_side got=%0b exp=1", in_flush_mode);
        end
        l1i_flush_complete = 1'b1;
        tick();
        l1i_flush_complete = 1'b0;
        #1;
        checks++;
        if (in_flush_mode !== 1'b0) begin
            errors++; $display("FAIL flush_single_i got=%0b exp=0", in_flush_mode);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        l1d_mem_req_valid = 1'b1;
        tick();
        l1d_mem_req_valid = 1'b0;
        l1i_mem_req_valid = 1'b1;
        tick();
        l1i_mem_req_valid = 1'b0;
        flush_req_l1d     = 1'b1;
        flush_req_l1i     = 1'b1;
        tick();
        flush_req_l1d = 1'b0;
        flush_req_l1i = 1'b0;
        #1;
        checks++;
        if ({l2_req_valid, in_flush_mode} !== 2'b11) begin
            errors++; $display("FAIL midrst_pre got=%0b%0b exp=11", l2_req_valid, in_flush_mode);
        end
        reset        = 1'b0;
        l2_rsp_valid = 1'b1;
        #1;
        checks++;
        if ({l1d_mem_rsp_valid, l1i_mem_rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL midrst_rsp got=%0b%0b exp=00", l1d_mem_rsp_valid, l1i_mem_rsp_valid);
        end
        tick();
        reset        = 1'b1;
        l2_rsp_valid = 1'b0;
        repeat (3) begin
            #1;
            checks++;
            if ({l2_req_valid, in_flush_mode, l1d_mem_rsp_valid, l1i_mem_rsp_valid} !== 4'b0000) begin
                errors++;
                $display("FAIL midrst_post got=%0b%0b%0b%0b exp=0000", l2_req_valid, in_flush_mode, l1d_mem_rsp_valid, l1i_mem_rsp_valid);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int owner;
        logic want_d, want_i, last_i, m_req, need_d, need_i;
        logic [AW-1:0] exp_addr;
        logic [OW-1:0] exp_opc;
        int pick;
        do_reset();
        owner = 0; want_d = 0; want_i = 0; last_i = 0; m_req = 0; need_d = 0; need_i = 0;
        for (int n = 0; n < 800; n++) begin
            l1d_mem_req_valid      = ($urandom_range(0, 2) == 0);
            l1i_mem_req_valid      = ($urandom_range(0, 2) == 0);
            l1d_mem_req_addr       = $urandom;
            l1i_mem_req_addr       = $urandom;
            l1d_mem_req_opcode     = OW'($urandom);
            l1i_mem_req_opcode     = OW'($urandom);
            l1d_mem_req_store_data = {$urandom, $urandom, $urandom, $urandom};
            l2_req_ack             = m_req && ($urandom_range(0, 2) == 0);
            l2_rsp_valid           = (owner != 0) && ($urandom_range(0, 3) == 0);
            flush_req_l1d          = ($urandom_range(0, 5) == 0);
            flush_req_l1i          = ($urandom_range(0, 5) == 0);
            l1d_flush_complete     = ($urandom_range(0, 3) == 0);
            l1i_flush_complete     = ($urandom_range(0, 3) == 0);
            #1;
            exp_addr = (owner == 2) ? l1i_mem_req_addr : l1d_mem_req_addr;
            exp_opc  = (owner == 2) ? l1i_mem_req_opcode : l1d_mem_req_opcode;
            checks++;
            if (l2_req_valid !== m_req) begin
                errors++; $display("FAIL rand_valid n=%0d got=%0b exp=%0b", n, l2_req_valid, m_req);
            end
            checks++;
            if ({l2_req_addr, l2_req_opcode} !== {exp_addr, exp_opc}) begin
                errors++; $display("FAIL rand_mux n=%0d got=%h/%0d exp=%h/%0d", n, l2_req_addr, l2_req_opcode, exp_addr, exp_opc);
            end
            checks++;
            if (l2_req_store_data !== l1d_mem_req_store_data) begin
                errors++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, l2_req_store_data, l1d_mem_req_store_data);
            end
            checks++;
            if ({l1d_mem_rsp_valid, l1i_mem_rsp_valid} !== {owner == 1 && l2_rsp_valid, owner == 2 && l2_rsp_valid}) begin
                errors++; $display("FAIL rand_rsp n=%0d got=%0b%0b owner=%0d rsp=%0b", n, l1d_mem_rsp_valid, l1i_mem_rsp_valid, owner, l2_rsp_valid);
            end
            checks++;
            if (in_flush_mode !== (need_d | need_i)) begin
                errors++; $display("FAIL rand_flush n=%0d got=%0b exp=%0b", n, in_flush_mode, need_d | need_i);
            end
            @(posedge clk);
            if (owner == 0) begin
                want_d = want_d | l1d_mem_req_valid;
                want_i = want_i | l1i_mem_req_valid;
                pick = 0;
                if (want_d && want_i) begin
`ifdef L1_ARB_ROUND_ROBIN_EN
                    pick = last_i ? 1 : 2;
`else
                    pick = 1;
`endif
                end else if (want_d) pick = 1;
                else if (want_i) pick = 2;
                if (pick != 0) begin
                    owner  = pick;
                    m_req  = 1'b1;
                    last_i = (pick == 2);
                    if (pick == 1) want_d = 1'b0;
                    else want_i = 1'b0;
                end
            end else begin
                if (owner == 1) want_i = want_i | l1i_mem_req_valid;
                else want_d = want_d | l1d_mem_req_valid;
                if (l2_req_ack || l2_rsp_valid) m_req = 1'b0;
                if (l2_rsp_valid) owner = 0;
            end
            if (!(need_d || need_i)) begin
                need_d = flush_req_l1d;
                need_i = flush_req_l1i;
            end else begin
                if (l1d_flush_complete) need_d = 1'b0;
                if (l1i_flush_complete) need_i = 1'b0;
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_d();
        test_tie();
        test_ack_and_pend();
        test_flush();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
